// File: rtl/pc_fetch_unit.sv
//------------------------------------------------------------------------------
// Module      : pc_fetch_unit
// Description : Program counter and instruction-fetch handshake for the
//               multicycle CPU; feeds and reloads from the jump-target adder.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_fetch_unit #(
    parameter int                    WORD_SIZE  = 32,
    parameter logic [WORD_SIZE-1:0]  RESET_PC   = '0,
    parameter int                    WAIT_LIMIT = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_start,
    input  logic                  take_branch,
    input  logic [WORD_SIZE-1:0]  jump_target,
    input  logic                  mem_ack,
    input  logic [WORD_SIZE-1:0]  mem_rdata,
    output logic                  mem_req,
    output logic [WORD_SIZE-1:0]  mem_addr,
    output logic [WORD_SIZE-1:0]  pc,
    output logic [WORD_SIZE-1:0]  offset_out,
    output logic [WORD_SIZE-1:0]  instr,
    output logic                  instr_valid,
    output logic                  fetch_err,
    output logic                  busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    localparam logic [7:0]           c_last_wait  = 8'(WAIT_LIMIT - 1);
    localparam logic [WORD_SIZE-1:0] c_pc_step    = WORD_SIZE'(4);
    localparam logic [WORD_SIZE-1:0] c_word_align = ~WORD_SIZE'(3);

    state_t                 r_state;
    logic [7:0]             r_wait_cnt;
    logic [WORD_SIZE-1:0]   r_pc;
    logic [WORD_SIZE-1:0]   r_instr;
    logic                   r_instr_valid;
    logic                   r_fetch_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_wait_cnt    <= '0;
            r_pc          <= RESET_PC;
            r_instr       <= '0;
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
        end else begin
            r_instr_valid <= 1'b0;
            r_fetch_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Branch load lands before FETCH starts, so a combined
                    // branch+fetch fetches from the new target.
                    if (take_branch) begin
                        r_pc <= jump_target & c_word_align;
                    end
                    if (fetch_start) begin
                        r_state    <= S_FETCH;
                        r_wait_cnt <= '0;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        r_instr       <= mem_rdata;
                        r_pc          <= r_pc + c_pc_step;
                        r_instr_valid <= 1'b1;
                        r_state       <= S_IDLE;
                    end else if (r_wait_cnt == c_last_wait) begin
                        r_fetch_err   <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wait_cnt    <= r_wait_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (r_state == S_FETCH);
    assign mem_req     = busy;
    assign pc          = r_pc;
    assign mem_addr    = r_pc;
    assign instr       = r_instr;
    assign instr_valid = r_instr_valid;
    assign fetch_err   = r_fetch_err;
    // Word-granular PC+4-relative displacement for the jump-target adder.
    assign offset_out  = {{(WORD_SIZE-18){r_instr[15]}}, r_instr[15:0], 2'b00};

endmodule

`default_nettype wire

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the program counter and runs the instruction-fetch handshake with instruction memory for the multicycle CPU.
- Latches the fetched word into the instruction register.
- Supplies PC and the sign-extended, word-shifted branch offset to the jump-target adder (jumpALU). Reloads PC from that adder's result when the control unit takes a branch or jump.
- Sits directly upstream of the jump-target adder and is also its consumer.

Parameters:
- word_size, 32, data/address width.
- reset_pc, 32'h0000_0000, PC value after reset.
- wait_limit, 15, maximum FETCH cycles without mem_ack before abort (1..255).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- fetch_start  input  1  control unit requests a fetch at current PC.
- take_branch  input  1  load PC from jump_target.
- jump_target  input  word_size  result of jump-target adder.
- mem_ack  input  1  memory has valid mem_rdata this cycle.
- mem_rdata  input  word_size  instruction word from memory.
- mem_req  output  1  fetch request, held until ack or abort.
- mem_addr  output  word_size  fetch address (= pc).
- pc  output  word_size  current PC; feeds adder inputPC.
- offset_out  output  word_size  {sign-extend(instr[15:0]), 2'b00}; feeds adder offset.
- instr  output  word_size  instruction register.
- instr_valid  output  1  one-cycle pulse: instr newly loaded.
- fetch_err  output  1  one-cycle pulse: fetch aborted on timeout.
- busy  output  1  high while in FETCH.

Behaviour:
- Reset (rst_n=0 at a rising edge) applies regardless of state, including mid-fetch:
  - state=IDLE, pc=reset_pc, instr=0, wait counter=0.
  - instr_valid=0, fetch_err=0, mem_req=0, busy=0.
  - Derived outputs follow: offset_out=0, mem_addr=reset_pc.
  - An ack arriving in the reset cycle is discarded.
- Two-state FSM (IDLE, FETCH). mem_req = busy = (state==FETCH); mem_addr = pc combinationally.
- IDLE:
  - fetch_start=1 -> FETCH, counter cleared.
  - mem_ack is ignored.
- FETCH:
  - mem_ack=1 -> instr<=mem_rdata, pc<=pc+4, instr_valid<=1 next cycle, -> IDLE.
  - mem_ack=0 with counter==wait_limit-1 -> fetch_err<=1 next cycle, pc and instr unchanged, -> IDLE.
  - Otherwise the counter increments.
  - fetch_start is ignored.
- Latency: fetch_start sampled at edge N -> mem_req high in cycle N+1. Ack sampled at edge M -> instr, pc and instr_valid visible after edge M. Zero-wait memory gives M=N+1.
- Branch load:
  - take_branch is honoured only in IDLE: pc<=jump_target with bits[1:0] forced to 0.
  - take_branch in FETCH is ignored; the control unit must not assert it while busy.
  - take_branch and fetch_start together in IDLE: PC loads the target and FETCH starts, so the fetch address is the new target.
- Offset semantics: pc has already advanced by 4 after a fetch, so pc + offset_out from the adder is the MIPS-style PC+4-relative target.
- Arithmetic: pc+4 is modulo 2^word_size, so 32'hFFFF_FFFC wraps to 0. No overflow flag.
- instr_valid and fetch_err are never high in the same cycle; each drops after one cycle.
- offset_out is a pure function of instr. Sign bit is instr[15]; the top bits are replicated and the result is shifted left by 2.

Test Plan:
- Reset, zero-wait fetch:
  - Reset, then fetch_start pulse; mem_ack=1 with mem_rdata=32'h1000_0003 in the first FETCH cycle.
  - Required: mem_req high one cycle at mem_addr=0; then instr=32'h1000_0003, pc=4, instr_valid pulses once, offset_out=32'h0000_000C.
- Wait states:
  - Ack after 3 wait cycles, rdata=32'h1000_FFFF.
  - Required: mem_req high 4 cycles at the same address, pc +4 once, offset_out=32'hFFFF_FFFC.
- Timeout:
  - No ack, wait_limit=15.
  - Required: mem_req high exactly 15 cycles, then fetch_err pulses once, pc and instr unchanged, busy low.
- Branch plus fetch in IDLE:
  - take_branch=1 with jump_target=32'h0000_0103 and fetch_start=1 in the same cycle.
  - Required: pc=32'h0000_0100 and the next fetch address is 32'h0000_0100. A take_branch during FETCH leaves pc unchanged.
- Wrap and reset mid-fetch:
  - reset_pc=32'hFFFF_FFFC; a fetch with ack gives pc=0.
  - Start another fetch and assert rst_n=0 mid-wait with ack in the same cycle.
  - Required: next cycle mem_req=0, pc=reset_pc, instr=0, no instr_valid.
